// File: rtl/line_window_gen.sv
// line_window_gen: KxK sliding-window generator over a raster pixel stream,
// built from K-1 cascaded line buffers and a K-column shift window.
module line_window_gen #(
    parameter int DATA_W  = 8,
    parameter int K       = 3,
    parameter int MAX_COL = 540,
    parameter int COL_W   = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [COL_W-1:0]        cols_i,
    input  logic [COL_W-1:0]        rows_i,
    input  logic [DATA_W-1:0]       data_i,
    input  logic                    data_en_i,
    output logic [K*K*DATA_W-1:0]   win_o,
    output logic                    win_en_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o
);
    localparam int W = K * DATA_W;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state_q;
    logic [COL_W-1:0]        cols_q, rows_q, col_q, row_q, col_d, row_d;
    logic                    busy_q, done_q, err_q, win_en_q;
    logic                    vld1_q, wen1_q, last1_q;
    logic [DATA_W-1:0]       pix_q;
    logic [DATA_W-1:0]       rd_q [K-1];
    logic [DATA_W-1:0]       lb_q [K-1][MAX_COL];
    logic [K*K*DATA_W-1:0]   win_q, win_d, out_q;
    logic [W-1:0]            colv;
    logic                    legal, accept, col_wrap, last, wen0;

    assign legal    = cols_i >= COL_W'(K) && cols_i <= COL_W'(MAX_COL) && rows_i >= COL_W'(K);
    assign accept   = state_q == RUN && data_en_i;
    assign col_wrap = col_q == cols_q - 1'b1;
    assign last     = col_wrap && row_q == rows_q - 1'b1;
    assign wen0     = accept && row_q >= COL_W'(K-1) && col_q >= COL_W'(K-1);
    assign col_d    = !accept ? col_q : col_wrap ? '0 : col_q + 1'b1;
    assign row_d    = (accept && col_wrap) ? row_q + 1'b1 : row_q;

    // buffer j holds the row j+1 lines above the current one; read-before-write
    always_ff @(posedge clk) begin
        if (accept) begin
            pix_q <= data_i;
            lb_q[0][col_q] <= data_i;
            rd_q[0] <= lb_q[0][col_q];
            for (int j = 1; j < K-1; j++) begin
                lb_q[j][col_q] <= lb_q[j-1][col_q];
                rd_q[j] <= lb_q[j][col_q];
            end
        end
    end

    // oldest row at r=0, newest column enters at c=K-1
    always_comb begin
        colv = '0;
        win_d = win_q;
        colv[(K-1)*DATA_W +: DATA_W] = pix_q;
        for (int r = 0; r < K-1; r++)
            colv[r*DATA_W +: DATA_W] = rd_q[K-2-r];
        for (int r = 0; r < K; r++)
            win_d[r*W +: W] = {colv[r*DATA_W +: DATA_W], win_q[r*W+DATA_W +: W-DATA_W]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cols_q   <= '0;
            rows_q   <= '0;
            col_q    <= '0;
            row_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            win_en_q <= 1'b0;
            vld1_q   <= 1'b0;
            wen1_q   <= 1'b0;
            last1_q  <= 1'b0;
            win_q    <= '0;
            out_q    <= '0;
        end else begin
            vld1_q   <= accept;
            wen1_q   <= wen0;
            last1_q  <= accept && last;
            win_en_q <= wen1_q;
            done_q   <= last1_q;
            busy_q   <= (state_q == IDLE && start_i && legal) || (busy_q && !done_q);
            if (vld1_q)
                win_q <= win_d;
            if (wen1_q)
                out_q <= win_d;
            col_q <= col_d;
            row_q <= row_d;
            if (state_q == IDLE && start_i) begin
                err_q <= !legal;
                if (legal) begin
                    state_q <= RUN;
                    cols_q  <= cols_i;
                    rows_q  <= rows_i;
                    col_q   <= '0;
                    row_q   <= '0;
                end
            end else if (accept && last) begin
                state_q <= IDLE;
            end
        end
    end

    assign win_o    = out_q;
    assign win_en_o = win_en_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign err_o    = err_q;
endmodule

// File: doc/line_window_gen.md
LINE_WINDOW_GEN -- requirements
Module: line_window_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel width in bits.
REQ-002 SHALL have parameter K, default 3, window size; legal values are odd, 3..7.
REQ-003 SHALL have parameter MAX_COL, default 540, line-buffer depth (maximum image width).
REQ-004 SHALL have parameter COL_W, default 10, width of the column/row size inputs.
REQ-005 SHALL have port clk, in, 1: single clock; every flop is rising-edge on clk.
REQ-006 SHALL have port rst_n, in, 1: asynchronous, active-low reset.
REQ-007 SHALL have port start_i, in, 1: frame start pulse; latches cols_i and rows_i.
REQ-008 SHALL have port cols_i, in, COL_W: image width; legal range K..MAX_COL.
REQ-009 SHALL have port rows_i, in, COL_W: image height; legal minimum K.
REQ-010 SHALL have port data_i, in, DATA_W: pixel, raster order.
REQ-011 SHALL have port data_en_i, in, 1: data_i valid this cycle.
REQ-012 SHALL have port win_o, out, K*K*DATA_W: KxK window.
REQ-013 SHALL have port win_en_o, out, 1: win_o valid, 1-cycle pulse per window.
REQ-014 SHALL have port busy_o, out, 1: frame in progress.
REQ-015 SHALL have port done_o, out, 1: 1-cycle end-of-frame pulse.
REQ-016 SHALL have port err_o, out, 1: sticky configuration-error flag.

Function
REQ-017 SHALL implement FSM states IDLE and RUN.
- IDLE -> RUN on start_i with legal cols_i/rows_i.
- RUN -> IDLE on acceptance of the pixel at (row=rows-1, col=cols-1).
REQ-018 SHALL, on start_i in IDLE with cols_i<K, cols_i>MAX_COL or rows_i<K:
- set err_o=1
- stay in IDLE.
REQ-019 SHALL clear err_o on any start_i in IDLE with a legal configuration.
REQ-020 SHALL ignore start_i while in RUN.
REQ-021 SHALL ignore data_en_i while in IDLE: no counter change, no window output.
REQ-022 SHALL clear the col and row counters on entry to RUN.
REQ-023 SHALL, on each accepted pixel in RUN:
- increment col;
- at col=cols-1, wrap col to 0 and increment row.
REQ-024 SHALL store each accepted pixel in K-1 cascaded line buffers (depth MAX_COL, addressed by col) and shift it into a K-column window register.
REQ-025 SHALL assert win_en_o exactly 2 cycles after the data_en_i cycle of the pixel at (row>=K-1, col>=K-1), one pulse per such pixel.
REQ-026 SHALL place element (r,c) of win_o at bits [(r*K+c)*DATA_W +: DATA_W].
- r=0 is row row-K+1; r=K-1 is the current row.
- c=0 is column col-K+1; c=K-1 is the current column.
REQ-027 SHALL emit exactly (cols-K+1)*(rows-K+1) windows per frame; windows never span a row wrap.
REQ-028 SHALL accept data_en_i gaps of any length with no loss, hold win_o stable between pulses, and apply latency per REQ-025 from each completing pixel.
REQ-029 SHALL assert done_o in the same cycle as the final win_en_o of a frame.
REQ-030 SHALL drive busy_o=1 from the cycle after a legal start_i until the cycle done_o is asserted, inclusive.
REQ-031 SHALL, when a legal start_i arrives in the cycle after done_o, begin a new frame with no stale-window output.

Reset
REQ-032 SHALL, on rst_n=0 (asynchronous, effective at any time including mid-frame):
- enter IDLE
- clear counters
- set win_o=0, win_en_o=0, busy_o=0, done_o=0, err_o=0.
REQ-033 SHALL flush the 2-stage output pipeline on reset so that no win_en_o occurs after reset release.
REQ-034 SHALL NOT require line-buffer contents to be cleared by reset.

Verification
REQ-035 K=3, cols=4, rows=3, pixels 0..11 continuous -> exactly 2 windows: {0,1,2,4,5,6,8,9,10} then {1,2,3,5,6,7,9,10,11}; done_o asserted with the 2nd window; busy_o falls.
REQ-036 Same frame with data_en_i every 3rd cycle -> identical windows, each win_en_o exactly 2 cycles after pixel 10 and pixel 11 respectively.
REQ-037 start_i with cols_i=2 -> err_o=1, busy_o=0, no windows; then legal start_i -> err_o=0.
REQ-038 rst_n pulse low after 5 pixels of a frame -> all outputs 0 immediately, no later win_en_o; new start_i plus full frame -> correct windows.
REQ-039 Two back-to-back 4x3 frames (second start_i the cycle after done_o, different data) -> second frame windows contain only second-frame pixels.
REQ-040 K=5 build, cols=540, rows=5, ramp data -> 536 windows, last window column range 535..539, done_o asserted once.
